// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: width helpers used by
// adder_tree and the row accumulator, plus the accumulator state encoding.
package conv_pkg;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_t;

   // Width of one kernel-row sum coming out of adder_tree.
   function automatic int in_width(input int data_w, input int weight_w, input int kernel);
      return data_w + weight_w + kernel;
   endfunction

   // Width that holds KERNEL_SIZE full-scale row sums without overflow.
   function automatic int acc_width(input int data_w, input int weight_w, input int kernel);
      return in_width(data_w, weight_w, kernel) + $clog2(kernel);
   endfunction

endpackage

// File: rtl/conv_row_accumulator_if.sv
// Row-sum input and window-result output handshakes of conv_row_accumulator.
// The master side is the upstream/consumer environment, the slave side is the block.
interface conv_row_accumulator_if
   import conv_pkg::*;
#(
   parameter int IN_WIDTH  = in_width(8, 8, 3),
   parameter int ACC_WIDTH = acc_width(8, 8, 3),
   parameter int OUT_WIDTH = 8
);
   logic                 acc_clear;
   logic                 acc_valid_in;
   logic                 acc_ready_in;
   logic [IN_WIDTH-1:0]  acc_dataIn;
   logic                 acc_valid_out;
   logic                 acc_ready_out;
   logic [ACC_WIDTH-1:0] acc_rawOut;
   logic [OUT_WIDTH-1:0] acc_dataOut;
   logic                 acc_sat;

   modport master (
      output acc_clear, acc_valid_in, acc_dataIn, acc_ready_out,
      input  acc_ready_in, acc_valid_out, acc_rawOut, acc_dataOut, acc_sat
   );

   modport slave (
      input  acc_clear, acc_valid_in, acc_dataIn, acc_ready_out,
      output acc_ready_in, acc_valid_out, acc_rawOut, acc_dataOut, acc_sat
   );
endinterface

// File: rtl/conv_requant.sv
// Combinational requantiser: right shift, then unsigned saturation to OUT_WIDTH.
// Shared by every output stage that narrows a full-precision sum.
module conv_requant #(
   parameter int ACC_WIDTH = 21,
   parameter int OUT_SHIFT = 8,
   parameter int OUT_WIDTH = 8
) (
   input  logic [ACC_WIDTH-1:0] raw,
   output logic [OUT_WIDTH-1:0] dataOut,
   output logic                 sat
);
   logic [ACC_WIDTH-1:0] q;

   assign q = raw >> OUT_SHIFT;

   generate
      if (OUT_WIDTH >= ACC_WIDTH) begin : g_wide
         assign sat     = 1'b0;
         assign dataOut = OUT_WIDTH'(q);
      end else begin : g_narrow
         // Any set bit above the output range means the value does not fit.
         assign sat     = |q[ACC_WIDTH-1:OUT_WIDTH];
         assign dataOut = sat ? {OUT_WIDTH{1'b1}} : q[OUT_WIDTH-1:0];
      end
   endgenerate
endmodule

// File: rtl/conv_row_accumulator.sv
// Accumulates KERNEL_SIZE adder_tree row sums into one window result and
// presents it, requantised, on a backpressured valid/ready output register.
module conv_row_accumulator
   import conv_pkg::*;
#(
   parameter int KERNEL_SIZE  = 3,
   parameter int DATA_WIDTH   = 8,
   parameter int WEIGHT_WIDTH = 8,
   parameter int OUT_SHIFT    = 8,
   parameter int OUT_WIDTH    = 8
) (
   input logic                   clk,
   input logic                   rstn,
   conv_row_accumulator_if.slave acc
);
   localparam int IN_WIDTH  = in_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, WEIGHT_WIDTH, KERNEL_SIZE);
   localparam int CNT_W     = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(KERNEL_SIZE - 1);

   acc_state_t           state_reg, state_next;
   logic [CNT_W-1:0]     cnt_reg, cnt_next;
   logic [ACC_WIDTH-1:0] acc_reg, acc_next;
   logic                 valid_reg, valid_next;
   logic [ACC_WIDTH-1:0] raw_reg, raw_next;
   logic [OUT_WIDTH-1:0] dout_reg, dout_next;
   logic                 sat_reg, sat_next;

   logic                 ready_in;
   logic                 beat;
   logic                 handshake;
   logic [ACC_WIDTH-1:0] row_sum;
   logic [OUT_WIDTH-1:0] q_data;
   logic                 q_sat;

   assign ready_in  = (state_reg == ACCUM) ? 1'b1 : acc.acc_ready_out;
   assign beat      = acc.acc_valid_in && ready_in;
   assign handshake = (state_reg == HOLD) && valid_reg && acc.acc_ready_out;
   // The counter sits at 0 in HOLD, so a beat taken there starts a fresh window.
   assign row_sum   = (cnt_reg == '0) ? ACC_WIDTH'(acc.acc_dataIn)
                                      : acc_reg + ACC_WIDTH'(acc.acc_dataIn);

   conv_requant #(
      .ACC_WIDTH(ACC_WIDTH),
      .OUT_SHIFT(OUT_SHIFT),
      .OUT_WIDTH(OUT_WIDTH)
   ) u_requant (
      .raw    (row_sum),
      .dataOut(q_data),
      .sat    (q_sat)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= ACCUM;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         valid_reg <= 1'b0;
         raw_reg   <= '0;
         dout_reg  <= '0;
         sat_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         valid_reg <= valid_next;
         raw_reg   <= raw_next;
         dout_reg  <= dout_next;
         sat_reg   <= sat_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      valid_next = valid_reg;
      raw_next   = raw_reg;
      dout_next  = dout_reg;
      sat_next   = sat_reg;

      if (acc.acc_clear) begin
         state_next = ACCUM;
         cnt_next   = '0;
         acc_next   = '0;
         valid_next = 1'b0;
         raw_next   = '0;
         dout_next  = '0;
         sat_next   = 1'b0;
      end else begin
         if (handshake) begin
            valid_next = 1'b0;
            state_next = ACCUM;
         end
         if (beat) begin
            acc_next = row_sum;
            if (cnt_reg == LAST_ROW) begin
               // Last row overrides the handshake so KERNEL_SIZE==1 can stream.
               cnt_next   = '0;
               raw_next   = row_sum;
               dout_next  = q_data;
               sat_next   = q_sat;
               valid_next = 1'b1;
               state_next = HOLD;
            end else begin
               cnt_next = cnt_reg + CNT_W'(1);
            end
         end
      end
   end

   assign acc.acc_ready_in  = ready_in;
   assign acc.acc_valid_out = valid_reg;
   assign acc.acc_rawOut    = raw_reg;
   assign acc.acc_dataOut   = dout_reg;
   assign acc.acc_sat       = sat_reg;
endmodule
